// File: rtl/stage2_align_accum.sv
// SD4 MAC stage 2: aligns nine partial products to the beat max exponent, sums them,
// and accumulates ACC_LEN beats into a block-floating-point result. Optional macro: ACC_SAT_EN.
module stage2_align_accum #(
    parameter int FRAC_BITS = 8,
    parameter int ACC_LEN   = 4,
    parameter int ACC_W     = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [44:0]      signed_pp_in,
    input  logic [44:0]      exp_in,
    input  logic [4:0]       exp_max_in,
    input  logic [4:0]       exp_bias_in,
    output logic             out_valid,
    output logic [ACC_W-1:0] acc_out,
    output logic [4:0]       exp_out,
    output logic [4:0]       exp_bias_out,
    output logic             ovf
);
    // in_valid qualifies every data input for one cycle; there is no ready, so every
    // qualified beat is consumed, and out_valid is a single-cycle pulse with no stall.
    localparam int AW    = 5 + FRAC_BITS;
    localparam int SUM_W = AW + 4;
    localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;

    logic signed [AW-1:0]    w_al;
    logic signed [4:0]       w_pp;
    logic [4:0]              w_e;
    logic [4:0]              w_d;
    logic signed [SUM_W-1:0] w_sum;

    logic                    r_a_valid;
    logic signed [SUM_W-1:0] r_sum;
    logic [4:0]              r_a_exp;
    logic [4:0]              r_a_bias;

    logic [CNT_W-1:0]        r_cnt;
    logic [ACC_W-1:0]        r_acc;
    logic [4:0]              r_acc_exp;
    logic                    r_out_valid;
    logic [ACC_W-1:0]        r_acc_out;
    logic [4:0]              r_exp_out;
    logic [4:0]              r_bias_out;

    logic [ACC_W-1:0]        w_sum_ext;
    logic [ACC_W-1:0]        w_lhs;
    logic [ACC_W-1:0]        w_rhs;
    logic [ACC_W-1:0]        w_acc_nxt;
    logic [4:0]              w_exp_nxt;
    logic                    w_first;
    logic                    w_last;

    // Arithmetic right shift where shifts past the width collapse to the sign.
    function automatic logic [ACC_W-1:0] sra(input logic [ACC_W-1:0] x, input logic [4:0] amt);
        if (32'(amt) >= ACC_W) return {ACC_W{x[ACC_W-1]}};
        return $signed(x) >>> amt;
    endfunction

    always_comb begin
        w_sum = '0;
        w_pp  = '0;
        w_e   = '0;
        w_d   = '0;
        w_al  = '0;
        for (int i = 0; i < 9; i++) begin
            w_pp = signed_pp_in[44-5*i -: 5];
            w_e  = exp_in[44-5*i -: 5];
            w_d  = (w_e > exp_max_in) ? 5'd0 : exp_max_in - w_e;
            w_al = {w_pp, {FRAC_BITS{1'b0}}};
            if (32'(w_d) >= AW) w_al = {AW{w_pp[4]}};
            else                w_al = w_al >>> w_d;
            w_sum = w_sum + SUM_W'(w_al);
        end
    end

    // Whichever operand has the smaller exponent is shifted down before the add.
    always_comb begin
        w_sum_ext = ACC_W'(r_sum);
        w_first   = (r_cnt == '0);
        w_last    = (r_cnt == CNT_W'(ACC_LEN - 1));
        w_lhs     = w_sum_ext;
        w_rhs     = '0;
        w_exp_nxt = r_a_exp;
        if (!w_first) begin
            if (r_a_exp > r_acc_exp) begin
                w_lhs = sra(r_acc, r_a_exp - r_acc_exp);
                w_rhs = w_sum_ext;
            end else begin
                w_lhs     = r_acc;
                w_rhs     = sra(w_sum_ext, r_acc_exp - r_a_exp);
                w_exp_nxt = r_acc_exp;
            end
        end
    end

`ifdef ACC_SAT_EN
    logic [ACC_W:0] w_ext;
    logic           w_sat_hit;
    logic           w_sat_nxt;
    logic           r_sat;
    logic           r_ovf;

    always_comb begin
        w_ext     = {w_lhs[ACC_W-1], w_lhs} + {w_rhs[ACC_W-1], w_rhs};
        w_sat_hit = (w_ext[ACC_W] != w_ext[ACC_W-1]);
        w_acc_nxt = w_sat_hit ? {w_ext[ACC_W], {(ACC_W-1){~w_ext[ACC_W]}}} : w_ext[ACC_W-1:0];
        w_sat_nxt = (w_first ? 1'b0 : r_sat) | w_sat_hit;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_sat <= 1'b0;
            if (rst) r_ovf <= 1'b0;
        end else if (r_a_valid) begin
            r_sat <= w_sat_nxt;
            if (w_last) r_ovf <= w_sat_nxt;
        end
    end
    assign ovf = r_ovf;
`else
    assign w_acc_nxt = w_lhs + w_rhs;
    assign ovf       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_valid   <= 1'b0;
            r_sum       <= '0;
            r_a_exp     <= '0;
            r_a_bias    <= '0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_acc_exp   <= '0;
            r_out_valid <= 1'b0;
            r_acc_out   <= '0;
            r_exp_out   <= '0;
            r_bias_out  <= '0;
        end else if (flush) begin
            r_a_valid   <= 1'b0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_a_valid   <= in_valid;
            r_out_valid <= 1'b0;
            if (in_valid) begin
                r_sum    <= w_sum;
                r_a_exp  <= exp_max_in;
                r_a_bias <= exp_bias_in;
            end
            if (r_a_valid) begin
                r_acc     <= w_acc_nxt;
                r_acc_exp <= w_exp_nxt;
                if (w_last) begin
                    r_cnt       <= '0;
                    r_out_valid <= 1'b1;
                    r_acc_out   <= w_acc_nxt;
                    r_exp_out   <= w_exp_nxt;
                    r_bias_out  <= r_a_bias;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign out_valid    = r_out_valid;
    assign acc_out      = r_acc_out;
    assign exp_out      = r_exp_out;
    assign exp_bias_out = r_bias_out;
endmodule

// File: tb/tb_stage2_align_accum.sv
// Directed bench for stage2_align_accum: four instances (ACC_LEN 4/1/2 and ACC_W=14) share one stimulus.
module tb_stage2_align_accum;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid;
  logic [44:0] signed_pp_in, exp_in;
  logic [4:0]  exp_max_in, exp_bias_in;

  logic        ov4, ov1, ov2, ov14;
  logic [19:0] acc4, acc1, acc2;
  logic [13:0] acc14;
  logic [4:0]  e4, e1, e2, e14, b4, b1, b2, b14;
  logic        ovf4, ovf1, ovf2, ovf14;

  int n_checks = 0;
  int n_errors = 0;
  int pulses4 = 0;
  int p_start;

  always #5 clk = ~clk;

  stage2_align_accum #(.FRAC_BITS(8), .ACC_LEN(4), .ACC_W(20)) u4 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .signed_pp_in(signed_pp_in),
    .exp_in(exp_in), .exp_max_in(exp_max_in), .exp_bias_in(exp_bias_in), .out_valid(ov4),
    .acc_out(acc4), .exp_out(e4), .exp_bias_out(b4), .ovf(ovf4));
  stage2_align_accum #(.FRAC_BITS(8), .ACC_LEN(1), .ACC_W(20)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .signed_pp_in(signed_pp_in),
    .exp_in(exp_in), .exp_max_in(exp_max_in), .exp_bias_in(exp_bias_in), .out_valid(ov1),
    .acc_out(acc1), .exp_out(e1), .exp_bias_out(b1), .ovf(ovf1));
  stage2_align_accum #(.FRAC_BITS(8), .ACC_LEN(2), .ACC_W(20)) u2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .signed_pp_in(signed_pp_in),
    .exp_in(exp_in), .exp_max_in(exp_max_in), .exp_bias_in(exp_bias_in), .out_valid(ov2),
    .acc_out(acc2), .exp_out(e2), .exp_bias_out(b2), .ovf(ovf2));
  stage2_align_accum #(.FRAC_BITS(8), .ACC_LEN(4), .ACC_W(14)) u14 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .signed_pp_in(signed_pp_in),
    .exp_in(exp_in), .exp_max_in(exp_max_in), .exp_bias_in(exp_bias_in), .out_valid(ov14),
    .acc_out(acc14), .exp_out(e14), .exp_bias_out(b14), .ovf(ovf14));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Inputs change right after a negedge; outputs are read there too.
  task automatic step();
    @(negedge clk);
    if (ov4) pulses4++;
  endtask

  task automatic vbeat(input logic [44:0] pp, input logic [44:0] ex, input logic [4:0] emax,
                       input logic [4:0] bias);
    signed_pp_in = pp;
    exp_in       = ex;
    exp_max_in   = emax;
    exp_bias_in  = bias;
    in_valid     = 1'b1;
    step();
    in_valid     = 1'b0;
  endtask

  task automatic ubeat(input logic [4:0] pp, input logic [4:0] ex, input logic [4:0] emax,
                       input logic [4:0] bias);
    vbeat({9{pp}}, {9{ex}}, emax, bias);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    signed_pp_in = '0; exp_in = '0; exp_max_in = '0; exp_bias_in = '0;
    step();
    do_reset();
    check("rst_out_valid", 32'(ov4), 32'd0);
    check("rst_acc_out", 32'(acc4), 32'd0);
    check("rst_exp_out", 32'(e4), 32'd0);
    check("rst_bias_out", 32'(b4), 32'd0);
    check("rst_ovf", 32'(ovf4), 32'd0);

    // Case 1 and case 6: four uniform beats, pulse exactly two cycles after the last.
    p_start = pulses4;
    ubeat(5'd1, 5'd3, 5'd3, 5'd2);
    ubeat(5'd1, 5'd3, 5'd3, 5'd2);
    ubeat(5'd1, 5'd3, 5'd3, 5'd2);
    ubeat(5'd1, 5'd3, 5'd3, 5'd9);
    check("c1_no_early_pulse", 32'(ov4), 32'd0);
    idle(1);
    check("c1_pulse", 32'(ov4), 32'd1);
    check("c1_acc", 32'(acc4), 32'd9216);
    check("c1_exp", 32'(e4), 32'd3);
    check("c1_bias", 32'(b4), 32'd9);
    check("c1_ovf", 32'(ovf4), 32'd0);
`ifdef ACC_SAT_EN
    check("c6_acc14", 32'(acc14), 32'h1FFF);
    check("c6_ovf14", 32'(ovf14), 32'd1);
`else
    check("c6_acc14", 32'(acc14), 32'h2400);
    check("c6_ovf14", 32'(ovf14), 32'd0);
`endif
    idle(1);
    check("c1_single_pulse", 32'(ov4), 32'd0);
    idle(3);
    check("c1_hold_acc", 32'(acc4), 32'd9216);
    check("c1_pulse_count", 32'(pulses4 - p_start), 32'd1);

    // Case 1 with gaps between beats.
    do_reset();
    ubeat(5'd1, 5'd3, 5'd3, 5'd0); idle(2);
    ubeat(5'd1, 5'd3, 5'd3, 5'd0); idle(1);
    ubeat(5'd1, 5'd3, 5'd3, 5'd0); idle(3);
    ubeat(5'd1, 5'd3, 5'd3, 5'd5);
    idle(1);
    check("gap_pulse", 32'(ov4), 32'd1);
    check("gap_acc", 32'(acc4), 32'd9216);
    check("gap_bias", 32'(b4), 32'd5);

    // Case 2: mixed exponents, single-beat window.
    do_reset();
    vbeat({5'd4, 5'h1C, 35'd0}, {5'd5, 5'd3, 35'd0}, 5'd5, 5'd1);
    idle(1);
    check("c2_pulse", 32'(ov1), 32'd1);
    check("c2_acc", 32'(acc1), 32'd768);
    check("c2_exp", 32'(e1), 32'd5);

    // Case 4: shift far past the width gives all sign bits.
    do_reset();
    vbeat({5'h1F, 5'd1, 35'd0}, 45'd0, 5'd20, 5'd0);
    idle(1);
    check("c4_acc", 32'(acc1), 32'h000FFFFF);
    check("c4_exp", 32'(e1), 32'd20);

    // Case 3: two-beat window, both exponent orders.
    do_reset();
    ubeat(5'd1, 5'd3, 5'd3, 5'd0);
    ubeat(5'd1, 5'd4, 5'd4, 5'd0);
    idle(1);
    check("c3a_pulse", 32'(ov2), 32'd1);
    check("c3a_acc", 32'(acc2), 32'd3456);
    check("c3a_exp", 32'(e2), 32'd4);
    do_reset();
    ubeat(5'd1, 5'd4, 5'd4, 5'd0);
    ubeat(5'd1, 5'd3, 5'd3, 5'd0);
    idle(1);
    check("c3b_acc", 32'(acc2), 32'd3456);
    check("c3b_exp", 32'(e2), 32'd4);

    // Case 5: partial window abandoned by rst.
    do_reset();
    p_start = pulses4;
    ubeat(5'd1, 5'd3, 5'd3, 5'd0);
    ubeat(5'd1, 5'd3, 5'd3, 5'd0);
    do_reset();
    for (int i = 0; i < 4; i++) ubeat(5'd1, 5'd3, 5'd3, 5'd0);
    idle(4);
    check("c5r_pulses", 32'(pulses4 - p_start), 32'd1);
    check("c5r_acc", 32'(acc4), 32'd9216);

    // Case 5 with flush; the flush cycle also carries a beat that must be dropped.
    do_reset();
    p_start = pulses4;
    ubeat(5'd1, 5'd3, 5'd3, 5'd0);
    ubeat(5'd1, 5'd3, 5'd3, 5'd0);
    flush = 1'b1;
    ubeat(5'd2, 5'd3, 5'd3, 5'd0);
    flush = 1'b0;
    for (int i = 0; i < 4; i++) ubeat(5'd1, 5'd3, 5'd3, 5'd0);
    idle(4);
    check("c5f_pulses", 32'(pulses4 - p_start), 32'd1);
    check("c5f_acc", 32'(acc4), 32'd9216);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
